// File: rtl/sct_pkg.sv
// Shared definitions for the sct sequencing front-end: FSM state encoding,
// stage thermometer codes and the sct output vector width.
package sct_pkg;

    localparam int SCT_RES_W = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } sct_seq_state_t;

    // Thermometer codes on sct pi08/pi07/pi06 (bit0 = pi06).
    localparam logic [2:0] STG_NONE = 3'b000;
    localparam logic [2:0] STG_ONE  = 3'b001;
    localparam logic [2:0] STG_TWO  = 3'b011;
    localparam logic [2:0] STG_FULL = 3'b111;

    // Fill the thermometer by one more bit; saturates at STG_FULL.
    function automatic logic [2:0] therm_next(input logic [2:0] s);
        return {s[1:0], 1'b1};
    endfunction

endpackage

// File: rtl/sct_seq_hold.sv
// Result register and valid/ready handshake for sct_seq.
// Optional HOLD watchdog enabled by macro SCT_SEQ_TIMEOUT_EN.
import sct_pkg::*;

module sct_seq_hold #(
    parameter int RES_W   = SCT_RES_W,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             capture,  // last RUN cycle: sample po
    input  logic             abort,
    input  logic [RES_W-1:0] po,
    input  logic             ready,
    output logic [RES_W-1:0] res,
    output logic             valid,
    output logic             err,
    output logic             done      // result leaves HOLD this edge
);

    logic [RES_W-1:0] res_q;
    logic             valid_q;
    logic             tmo;

`ifdef SCT_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Timeout only counts ready-low cycles, so a same-edge handshake always wins.
    assign tmo = valid_q & ~ready & (wd_q == WD_W'(TIMEOUT - 1));

    // Watchdog: restarts on each capture, advances while the result is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (capture)
                wd_q <= '0;
            else if (valid_q & ~ready & ~tmo)
                wd_q <= wd_q + 1'b1;
            if (tmo & ~abort)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT != 0);
    assign tmo        = 1'b0;
    assign err        = 1'b0;
`endif

    // Result capture and valid flag; res keeps its last value across abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else if (abort) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            res_q   <= po;
            valid_q <= 1'b1;
        end else if (valid_q & (ready | tmo)) begin
            valid_q <= 1'b0;
        end
    end

    assign res   = res_q;
    assign valid = valid_q;
    assign done  = valid_q & (ready | tmo);

endmodule

// File: rtl/sct_seq.sv
// sct_seq: drives the sct progress chain (stage thermometer + down-counter)
// and hands the captured sct outputs downstream over valid/ready.
// Optional HOLD watchdog enabled by macro SCT_SEQ_TIMEOUT_EN.
import sct_pkg::*;

module sct_seq #(
    parameter int CNT_W   = 5,
    parameter int RES_W   = SCT_RES_W,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] load_i,
    output logic [2:0]       stage_o,
    output logic [CNT_W-1:0] cnt_o,
    input  logic [RES_W-1:0] sct_po_i,
    output logic [RES_W-1:0] res_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic             err_o
);

    sct_seq_state_t   state_q, state_d;
    logic [2:0]       stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             capture;
    logic             hold_done;

    // State, progress-chain and busy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            stage_q <= STG_NONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Next-state: abort beats everything; en_i low freezes ARM and RUN.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            stage_d = STG_NONE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i & en_i) begin
                        state_d = S_ARM;
                        stage_d = STG_ONE;
                        cnt_d   = load_i;
                    end
                end
                S_ARM: begin
                    if (en_i) begin
                        stage_d = therm_next(stage_q);
                        if (stage_q == STG_FULL)
                            state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (en_i) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            capture = 1'b1;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_done) begin
                        state_d = S_IDLE;
                        stage_d = STG_NONE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    stage_d = STG_NONE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    sct_seq_hold #(
        .RES_W   (RES_W),
        .TIMEOUT (TIMEOUT)
    ) u_hold (
        .clock   (clock),
        .reset   (reset),
        .capture (capture),
        .abort   (abort_i),
        .po      (sct_po_i),
        .ready   (res_ready_i),
        .res     (res_o),
        .valid   (res_valid_o),
        .err     (err_o),
        .done    (hold_done)
    );

    assign stage_o = stage_q;
    assign cnt_o   = cnt_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_sct_seq.sv
// Directed bench for sct_seq; expected values are hand-derived from the
// sequence timing (start at t: ARM t+1..t+3, RUN t+4..t+4+load, valid t+5+load).
module tb_sct_seq;

    logic        clock;
    logic        reset;
    logic        en_i;
    logic        start_i;
    logic        abort_i;
    logic [4:0]  load_i;
    logic [2:0]  stage_o;
    logic [4:0]  cnt_o;
    logic [14:0] sct_po_i;
    logic [14:0] res_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        busy_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    sct_seq #(.CNT_W(5), .RES_W(15), .TIMEOUT(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .en_i        (en_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .load_i      (load_i),
        .stage_o     (stage_o),
        .cnt_o       (cnt_o),
        .sct_po_i    (sct_po_i),
        .res_o       (res_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b1; en_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        load_i = '0; sct_po_i = '0; res_ready_i = 1'b0;
        step(); step();
        chk("rst_stage", 32'(stage_o), 32'h0);
        chk("rst_cnt",   32'(cnt_o),   32'h0);
        chk("rst_res",   32'(res_o),   32'h0);
        chk("rst_valid", 32'(res_valid_o), 32'h0);
        chk("rst_busy",  32'(busy_o),  32'h0);
        chk("rst_err",   32'(err_o),   32'h0);
        reset = 1'b0;
        step();

        // Basic: load 3, ready high, sct_po 1A5A.
        en_i = 1'b1; res_ready_i = 1'b1; sct_po_i = 15'h1A5A; load_i = 5'd3; start_i = 1'b1;
        step(); start_i = 1'b0;                      // t+1
        chk("b_stage1", 32'(stage_o), 32'h1);
        chk("b_busy1",  32'(busy_o),  32'h1);
        step(); chk("b_stage2", 32'(stage_o), 32'h3); // t+2
        step(); chk("b_stage3", 32'(stage_o), 32'h7); // t+3
        step(); chk("b_cnt3", 32'(cnt_o), 32'd3);     // t+4
        chk("b_stage_run", 32'(stage_o), 32'h7);
        step(); chk("b_cnt2", 32'(cnt_o), 32'd2);     // t+5
        step(); chk("b_cnt1", 32'(cnt_o), 32'd1);     // t+6
        step(); chk("b_cnt0", 32'(cnt_o), 32'd0);     // t+7
        chk("b_novalid", 32'(res_valid_o), 32'h0);
        step();                                       // t+8
        chk("b_valid", 32'(res_valid_o), 32'h1);
        chk("b_res",   32'(res_o), 32'h1A5A);
        chk("b_busy8", 32'(busy_o), 32'h1);
        sct_po_i = 15'h0000;
        step();                                       // t+9
        chk("b_valid_clr", 32'(res_valid_o), 32'h0);
        chk("b_busy_low",  32'(busy_o), 32'h0);
        chk("b_res_keep",  32'(res_o), 32'h1A5A);
        chk("b_stage_clr", 32'(stage_o), 32'h0);

        // load 0; start during HOLD must be ignored. Restart in first IDLE cycle.
        res_ready_i = 1'b0; load_i = 5'd0; sct_po_i = 15'h0123; start_i = 1'b1;
        step(); start_i = 1'b0;                       // t+1
        step(); step(); step();                       // t+4 RUN
        chk("z_cnt0", 32'(cnt_o), 32'd0);
        chk("z_novalid", 32'(res_valid_o), 32'h0);
        step();                                       // t+5
        chk("z_valid", 32'(res_valid_o), 32'h1);
        chk("z_res", 32'(res_o), 32'h0123);
        start_i = 1'b1; load_i = 5'd7;
        step();
        chk("z_hold_valid", 32'(res_valid_o), 32'h1);
        chk("z_hold_stage", 32'(stage_o), 32'h7);
        chk("z_hold_cnt", 32'(cnt_o), 32'd0);
        start_i = 1'b0; res_ready_i = 1'b1;
        step();
        chk("z_xfer_valid", 32'(res_valid_o), 32'h0);
        chk("z_xfer_busy", 32'(busy_o), 32'h0);
        step();
        chk("z_no_queue", 32'(busy_o), 32'h0);

        // Freeze: en low two cycles at cnt 2 delays valid by two.
        load_i = 5'd4; sct_po_i = 15'h2BCD; start_i = 1'b1;
        step(); start_i = 1'b0;                       // t+1
        step(); step(); step();                       // t+4 cnt 4
        chk("f_cnt4", 32'(cnt_o), 32'd4);
        step(); step();                               // t+6 cnt 2
        chk("f_cnt2", 32'(cnt_o), 32'd2);
        en_i = 1'b0;
        step(); chk("f_frz1", 32'(cnt_o), 32'd2);     // t+7
        step(); chk("f_frz2", 32'(cnt_o), 32'd2);     // t+8
        en_i = 1'b1;
        step(); chk("f_cnt1", 32'(cnt_o), 32'd1);     // t+9
        chk("f_novalid9", 32'(res_valid_o), 32'h0);
        step(); chk("f_novalid10", 32'(res_valid_o), 32'h0); // t+10
        step();                                       // t+11
        chk("f_valid", 32'(res_valid_o), 32'h1);
        chk("f_res", 32'(res_o), 32'h2BCD);
        step();
        chk("f_idle", 32'(busy_o), 32'h0);

        // Abort + start in HOLD with ready high.
        res_ready_i = 1'b0; load_i = 5'd1; sct_po_i = 15'h5555; start_i = 1'b1;
        step(); start_i = 1'b0;
        step(); step(); step(); step();               // t+5 cnt 0
        step();                                       // t+6 HOLD
        chk("a_valid", 32'(res_valid_o), 32'h1);
        abort_i = 1'b1; start_i = 1'b1; res_ready_i = 1'b1;
        step();
        chk("a_valid0", 32'(res_valid_o), 32'h0);
        chk("a_busy0",  32'(busy_o), 32'h0);
        chk("a_stage0", 32'(stage_o), 32'h0);
        chk("a_res_keep", 32'(res_o), 32'h5555);
        abort_i = 1'b0; start_i = 1'b0;
        step();
        chk("a_no_seq", 32'(busy_o), 32'h0);
        chk("a_no_arm", 32'(stage_o), 32'h0);

`ifdef SCT_SEQ_TIMEOUT_EN
        // Watchdog: ready held low, valid drops after 16 HOLD cycles.
        res_ready_i = 1'b0; load_i = 5'd0; sct_po_i = 15'h0777; start_i = 1'b1;
        step(); start_i = 1'b0;
        step(); step(); step(); step();               // t+5 HOLD
        chk("t_valid", 32'(res_valid_o), 32'h1);
        for (int i = 0; i < 15; i++) step();          // t+20
        chk("t_valid_last", 32'(res_valid_o), 32'h1);
        chk("t_err_pre", 32'(err_o), 32'h0);
        step();                                       // t+21
        chk("t_valid_drop", 32'(res_valid_o), 32'h0);
        chk("t_err", 32'(err_o), 32'h1);
        chk("t_idle", 32'(busy_o), 32'h0);
        res_ready_i = 1'b1; start_i = 1'b1;
        step(); start_i = 1'b0;
        step(); step(); step(); step();
        chk("t_valid2", 32'(res_valid_o), 32'h1);
        step();
        chk("t_err_sticky", 32'(err_o), 32'h1);
`endif

        // Reset mid-RUN at cnt 2.
        res_ready_i = 1'b0; load_i = 5'd5; sct_po_i = 15'h3C3C; start_i = 1'b1;
        step(); start_i = 1'b0;
        step(); step(); step();                       // t+4 cnt 5
        step(); step(); step();                       // t+7 cnt 2
        chk("r_cnt2", 32'(cnt_o), 32'd2);
        reset = 1'b1;
        #1;
        chk("r_stage", 32'(stage_o), 32'h0);
        chk("r_cnt",   32'(cnt_o),   32'h0);
        chk("r_res",   32'(res_o),   32'h0);
        chk("r_valid", 32'(res_valid_o), 32'h0);
        chk("r_busy",  32'(busy_o),  32'h0);
        chk("r_err",   32'(err_o),   32'h0);
        step();
        reset = 1'b0;
        step(); step();
        chk("r_idle_busy", 32'(busy_o), 32'h0);
        chk("r_idle_stage", 32'(stage_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
